// File: rtl/apb_timer_slave_if.sv
// APB2 bus bundle between the AHB-to-APB bridge (master) and a timer slave.
// Signals: Pselx[2:0] slave selects, Penable access strobe, Pwrite direction,
// Paddr address, Pwdata write data, Prdata read data returned by the slave.
interface apb_timer_slave_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (output Pselx, output Penable, output Pwrite,
                    output Paddr, output Pwdata, input Prdata);
    modport slave  (input Pselx, input Penable, input Pwrite,
                    input Paddr, input Pwdata, output Prdata);
endinterface

// File: rtl/apb_timer_slave.sv
// APB2 timer peripheral: register bank (CTRL, LOAD, COUNT, STATUS, SCRATCH)
// and a prescaled 32-bit down-counter with sticky expiry flag and interrupt.
// Ports:
//   Hclk    - single clock
//   Hreset  - asynchronous active-high reset
//   bus     - APB2 slave modport (zero wait states, no Pready/Pslverr)
//   Irq     - level interrupt, EXP & IRQ_EN
module apb_timer_slave #(
    parameter int SEL_IDX  = 0,
    parameter int PRESCALE = 4
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    apb_timer_slave_if.slave     bus,
    output logic                 Irq
);

    localparam logic [5:0]  OFF_CTRL    = 6'd0;
    localparam logic [5:0]  OFF_LOAD    = 6'd1;
    localparam logic [5:0]  OFF_COUNT   = 6'd2;
    localparam logic [5:0]  OFF_STATUS  = 6'd3;
    localparam logic [5:0]  OFF_SCRATCH = 6'd4;
    localparam logic [31:0] PCNT_LAST   = 32'(PRESCALE - 1);

    logic        r_en;
    logic        r_reload;
    logic        r_irq_en;
    logic        r_exp;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [31:0] r_scratch;
    logic [31:0] r_pcnt;
    logic [31:0] r_prdata;

    logic        w_sel;
    logic        w_access;
    logic        w_rd_setup;
    logic        w_wr;
    logic [5:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_status;
    logic        w_wr_scratch;
    logic        w_tick;
    logic        w_expire;
    logic        w_en_next;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel        = bus.Pselx[SEL_IDX];
    assign w_access     = w_sel & bus.Penable;
    assign w_rd_setup   = w_sel & ~bus.Penable & ~bus.Pwrite;
    assign w_wr         = w_access & bus.Pwrite;
    assign w_off        = bus.Paddr[7:2];
    assign w_wr_ctrl    = w_wr & (w_off == OFF_CTRL);
    assign w_wr_load    = w_wr & (w_off == OFF_LOAD);
    assign w_wr_status  = w_wr & (w_off == OFF_STATUS);
    assign w_wr_scratch = w_wr & (w_off == OFF_SCRATCH);

    assign w_tick   = r_en & (r_pcnt == PCNT_LAST);
    // A LOAD write on a tick edge suppresses both decrement and expiry.
    assign w_expire = w_tick & (r_count == 32'd0) & ~w_wr_load;

    assign Irq        = r_exp & r_irq_en;
    assign bus.Prdata = r_prdata;
    assign w_unused   = &{1'b0, bus.Paddr[31:8], bus.Paddr[1:0], bus.Pselx};

    // Next EN: a CTRL write overrides the one-shot auto-clear.
    always_comb begin
        w_en_next = r_en;
        if (w_wr_ctrl) begin
            w_en_next = bus.Pwdata[0];
        end else if (w_expire && !r_reload) begin
            w_en_next = 1'b0;
        end else begin
            w_en_next = r_en;
        end
    end

    // Read data multiplexer; undecoded offsets read as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_CTRL:    w_rdata = {29'd0, r_irq_en, r_reload, r_en};
            OFF_LOAD:    w_rdata = r_load;
            OFF_COUNT:   w_rdata = r_count;
            OFF_STATUS:  w_rdata = {31'd0, r_exp};
            OFF_SCRATCH: w_rdata = r_scratch;
            default:     w_rdata = 32'd0;
        endcase
    end

    // Register bank, prescaler and down-counter.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_en      <= 1'b0;
            r_reload  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_exp     <= 1'b0;
            r_load    <= 32'd0;
            r_count   <= 32'd0;
            r_scratch <= 32'd0;
            r_pcnt    <= 32'd0;
        end else begin
            r_en <= w_en_next;
            if (w_wr_ctrl) begin
                r_reload <= bus.Pwdata[1];
                r_irq_en <= bus.Pwdata[2];
            end else begin
                r_reload <= r_reload;
                r_irq_en <= r_irq_en;
            end

            // Prescaler restarts when disabled, on a 0->1 EN edge, or on wrap.
            if (!w_en_next || !r_en || w_tick) begin
                r_pcnt <= 32'd0;
            end else begin
                r_pcnt <= r_pcnt + 32'd1;
            end

            if (w_wr_load) begin
                r_load  <= bus.Pwdata;
                r_count <= bus.Pwdata;
            end else if (w_tick && (r_count != 32'd0)) begin
                r_count <= r_count - 32'd1;
            end else if (w_expire && r_reload) begin
                r_count <= r_load;
            end else begin
                r_count <= r_count;
            end

            // Expiry set beats a same-cycle write-1-to-clear.
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_wr_status && bus.Pwdata[0]) begin
                r_exp <= 1'b0;
            end else begin
                r_exp <= r_exp;
            end

            if (w_wr_scratch) begin
                r_scratch <= bus.Pwdata;
            end else begin
                r_scratch <= r_scratch;
            end
        end
    end

    // Read data: captured at end of read setup, cleared at end of any access.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_prdata <= 32'd0;
        end else if (w_rd_setup) begin
            r_prdata <= w_rdata;
        end else if (w_access) begin
            r_prdata <= 32'd0;
        end else begin
            r_prdata <= r_prdata;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed APB transfers, expected
// read data queued at issue time and compared by an independent monitor.
module tb_apb_timer_slave;

    localparam int SEL = 0;
    localparam logic [31:0] A_CTRL  = 32'h0000_0000;
    localparam logic [31:0] A_LOAD  = 32'h0000_0004;
    localparam logic [31:0] A_COUNT = 32'h0000_0008;
    localparam logic [31:0] A_STAT  = 32'h0000_000C;
    localparam logic [31:0] A_SCR   = 32'h0000_0010;
    localparam logic [31:0] A_BAD   = 32'h0000_0040;

    logic Hclk;
    logic Hreset;
    logic Irq;

    apb_timer_slave_if bus ();

    apb_timer_slave #(.SEL_IDX(SEL), .PRESCALE(4)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus),
        .Irq    (Irq)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        prev_rd_acc = 1'b0;

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares Prdata in every read access phase, and requires it
    // to be zero in the cycle after a read access.
    always @(negedge Hclk) begin
        logic        rd_acc;
        logic [31:0] e;
        string       nm;
        rd_acc = bus.Pselx[SEL] && bus.Penable && !bus.Pwrite && !Hreset;
        if (prev_rd_acc) check("prdata_clear", bus.Prdata, 32'd0);
        if (rd_acc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got read with Prdata %h expected no read", bus.Prdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, bus.Prdata, e);
            end
        end
        prev_rd_acc = rd_acc;
    end

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] psel = 3'b001);
        bus.Pselx = psel; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
        bus.Paddr = addr; bus.Pwdata = data;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Paddr = addr;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
    endtask

    task automatic idle(input int n);
        bus.Pselx = 3'b000; bus.Penable = 1'b0;
        repeat (n) begin
            @(posedge Hclk); #1;
        end
    endtask

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] ar_addr [10] = '{A_COUNT, A_COUNT, A_COUNT, A_STAT, A_STAT,
                                  A_COUNT, A_COUNT, A_COUNT, A_COUNT, A_COUNT};
    logic [31:0] ar_exp  [10] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd1,
                                  32'd2, 32'd1, 32'd0, 32'd0, 32'd2};
    int          ar_idle [10] = '{2, 2, 0, 0, 0, 0, 2, 0, 0, 0};
    logic [31:0] zero_addr [5] = '{A_CTRL, A_LOAD, A_COUNT, A_STAT, A_SCR};

    initial begin
        Hreset = 1'b1;
        bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
        bus.Paddr = 32'd0;  bus.Pwdata = 32'd0;
        repeat (2) @(posedge Hclk);
        #1;
        check("reset_prdata", bus.Prdata, 32'd0);
        check("reset_irq", {31'd0, Irq}, 32'd0);
        Hreset = 1'b0;
        @(posedge Hclk); #1;

        // Register read/write and decode
        apb_write(A_SCR, 32'hA5A5_5A5A);
        apb_read(A_SCR, 32'hA5A5_5A5A, "scratch_rb");
        apb_read(32'hFFFF_FF13, 32'hA5A5_5A5A, "scratch_alias");
        apb_write(A_LOAD, 32'h0000_0055);
        apb_write(A_COUNT, 32'h0000_1234);
        apb_read(A_COUNT, 32'h0000_0055, "count_ro");
        apb_read(A_BAD, 32'd0, "bad_offset");
        apb_read(A_LOAD, 32'h0000_0055, "load_rb");
        apb_write(A_CTRL, 32'hFFFF_FFFF);
        apb_read(A_CTRL, 32'h0000_0007, "ctrl_mask");
        apb_write(A_CTRL, 32'd0);
        apb_read(A_STAT, 32'd0, "status_idle");
        idle(1);

        // One-shot: LOAD=3, CTRL=EN|IRQ_EN; expiry 16 clocks after EN edge
        apb_write(A_LOAD, 32'd3);
        apb_write(A_CTRL, 32'h5);
        for (int k = 0; k < 4; k++) begin
            apb_read(A_COUNT, 32'(3 - k), "os_count");
            if (k < 3) idle(2);
        end
        idle(1);
        check("os_irq_early", {31'd0, Irq}, 32'd0);
        idle(1);
        check("os_irq_rise", {31'd0, Irq}, 32'd1);
        apb_read(A_CTRL, 32'h4, "os_ctrl");
        apb_read(A_STAT, 32'h1, "os_exp");
        apb_read(A_COUNT, 32'd0, "os_count_hold");
        apb_write(A_STAT, 32'd0);
        check("status_w0", {31'd0, Irq}, 32'd1);
        apb_write(A_STAT, 32'd1);
        check("irq_clear", {31'd0, Irq}, 32'd0);
        idle(1);

        // Auto-reload: LOAD=2, CTRL=EN|RELOAD
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h3);
        for (int k = 0; k < 10; k++) begin
            apb_read(ar_addr[k], ar_exp[k], "ar_seq");
            if (ar_idle[k] > 0) idle(ar_idle[k]);
        end
        check("ar_irq_off", {31'd0, Irq}, 32'd0);

        // Reset mid-count and mid-read
        apb_write(A_CTRL, 32'h7);
        check("pre_rst_irq", {31'd0, Irq}, 32'd1);
        bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Paddr = A_SCR;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        check("pre_rst_prdata", bus.Prdata, 32'hA5A5_5A5A);
        #1 Hreset = 1'b1;
        #1;
        check("rst_mid_prdata", bus.Prdata, 32'd0);
        check("rst_mid_irq", {31'd0, Irq}, 32'd0);
        bus.Pselx = 3'b000; bus.Penable = 1'b0;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        idle(1);
        for (int k = 0; k < 5; k++) apb_read(zero_addr[k], 32'd0, "post_rst_zero");
        idle(1);

        // Collision: STATUS clear on the expiry edge
        apb_write(A_LOAD, 32'd0);
        apb_write(A_CTRL, 32'h1);
        idle(2);
        apb_write(A_STAT, 32'd1);
        apb_read(A_STAT, 32'd1, "col_set_wins");
        apb_write(A_STAT, 32'd1);
        apb_read(A_STAT, 32'd0, "col_cleared");

        // Collision: LOAD write on a tick edge
        apb_write(A_LOAD, 32'd5);
        apb_write(A_CTRL, 32'h3);
        idle(2);
        apb_write(A_LOAD, 32'd7);
        apb_read(A_COUNT, 32'd7, "col_load_wins");

        // Collision: CTRL write on a one-shot expiry edge
        apb_write(A_CTRL, 32'd0);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_CTRL, 32'h1);
        idle(2);
        apb_write(A_CTRL, 32'h1);
        apb_read(A_CTRL, 32'h1, "col_ctrl_wins");
        apb_write(A_CTRL, 32'd0);
        idle(1);

        // Protocol: foreign select ignored, back-to-back transfers
        apb_write(A_SCR, 32'h1111_2222);
        apb_write(A_SCR, 32'hDEAD_BEEF, 3'b010);
        idle(1);
        bus.Pselx = 3'b010; bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Paddr = A_SCR;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        check("foreign_sel_prdata", bus.Prdata, 32'd0);
        @(posedge Hclk); #1;
        check("foreign_sel_prdata2", bus.Prdata, 32'd0);
        idle(1);
        apb_read(A_SCR, 32'h1111_2222, "foreign_sel_nowrite");
        apb_write(A_SCR, 32'h3333_4444);
        apb_read(A_SCR, 32'h3333_4444, "b2b_wr_rd");
        apb_read(A_SCR, 32'h3333_4444, "b2b_rd");
        apb_write(A_SCR, 32'h5555_6666);
        apb_read(A_SCR, 32'h5555_6666, "b2b_rd_wr_commit");
        idle(2);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB peripheral that sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's APB outputs (one bit of `Pselx`, plus `Penable`, `Pwrite`, `Paddr` and `Pwdata`) and returns `Prdata`. It contains a small register bank and a prescaled 32-bit down-counter timer with a sticky expiry flag and an interrupt output. The protocol is APB2: no `Pready`, no `Pslverr`, and zero wait states, matching what the bridge drives.

## Interface
- `SEL_IDX`, default 0: index of the `Pselx` bit that selects this slave (0..2).
- `PRESCALE`, default 4: clocks per timer tick; legal values are ≥1.

Ports:
- `Hclk`  in  1  single clock for the whole block.
- `Hreset`  in  1  asynchronous, active-high reset.
- `Pselx`  in  3  slave selects from the bridge; only `Pselx[SEL_IDX]` is used, called `sel` below.
- `Penable`  in  1  APB access-phase strobe.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  address; only `Paddr[7:2]` is decoded.
- `Pwdata`  in  32  write data.
- `Prdata`  out  32  read data to the bridge.
- `Irq`  out  1  timer interrupt, level, active-high.

## Operation
Register map (offset = `Paddr[7:0]`, `Paddr[1:0]` ignored):
- 0x00 CTRL (r/w)
  - bit0 EN, bit1 RELOAD, bit2 IRQ_EN.
  - Bits 31:3 read as 0; writes to them are ignored.
- 0x04 LOAD (r/w): reload value. A write also loads COUNT with `Pwdata`.
- 0x08 COUNT (read-only): current count. Writes are ignored.
- 0x0C STATUS
  - bit0 EXP, sticky; writing 1 clears it, writing 0 has no effect.
  - Other bits read as 0.
- 0x10 SCRATCH (r/w): 32-bit general-purpose register.
- Any other offset: reads return 0; writes are ignored.

APB phases:
- Setup phase = `sel & !Penable`.
- Access phase = `sel & Penable`.
- Write commit: the register updates on the `Hclk` edge that ends the access phase with `Pwrite`=1.
- Read capture: `Prdata` is loaded on the edge that ends the setup phase with `Pwrite`=0. It holds that value through the access phase and is cleared to 0 on the edge that ends the access phase.
- If `sel` is low, nothing happens; `Penable` without `sel` is ignored.

Timer:
- Prescaler `pcnt` counts 0..PRESCALE-1 while EN=1. A tick occurs on the cycle where `pcnt`=PRESCALE-1; `pcnt` then wraps to 0.
- With EN=0, `pcnt` is held at 0.
- A CTRL write that changes EN from 0 to 1 resets `pcnt` to 0.
- On a tick:
  - If COUNT≠0: COUNT ← COUNT−1.
  - If COUNT=0: EXP ← 1. Then, if RELOAD=1, COUNT ← LOAD; if RELOAD=0, COUNT stays 0 and EN ← 0 (one-shot).
- `Irq` = EXP & IRQ_EN, decoded combinationally from registered state.

Simultaneous events (fixed priorities):
- STATUS write-1-to-clear in the same cycle as an expiry: the set wins, so EXP=1.
- LOAD write in the same cycle as a tick: the write wins, so COUNT=`Pwdata`. No decrement happens and no expiry is evaluated that cycle.
- CTRL write in the same cycle as a one-shot expiry: the written CTRL value wins, including EN.
- COUNT read in the same cycle as a tick: `Prdata` captures the pre-update value.

## Timing
- Reset (asynchronous, immediate) clears CTRL, LOAD, COUNT, EXP, SCRATCH and `pcnt` to 0. As a result `Prdata`=0 and `Irq`=0.
- Reset asserted mid-transfer or mid-count aborts the operation. After release the block is idle and the next transfer must start with a setup phase.
- Write latency: the new value is visible to a read whose setup phase begins in the cycle after the access phase.
- Timer latency:
  - The first tick comes PRESCALE clocks after the edge that sets EN.
  - Expiry from LOAD=N comes (N+1)·PRESCALE clocks after EN is set.
  - `Irq` rises on that same edge when IRQ_EN=1.
- Back-to-back transfers (setup → access → setup) are supported with no idle cycle.

## Test plan
- Reset: assert `Hreset` mid-count. Required: all outputs 0 immediately. Reading offsets 0x00, 0x04, 0x08, 0x0C and 0x10 afterwards returns 0.
- Register R/W:
  - Write SCRATCH=0xA5A5_5A5A and read it back → 0xA5A5_5A5A.
  - Write CTRL=0xFFFF_FFFF and read it back → 0x0000_0007.
  - Write COUNT=0x1234 → no change.
  - Read offset 0x40 → 0.
- One-shot (PRESCALE=4): write LOAD=3, then CTRL=0x5.
  - COUNT reads 3, 2, 1, 0 at 4-clock spacing.
  - EXP and `Irq` rise 16 clocks after EN is set.
  - CTRL then reads 0x4.
  - Writing STATUS=1 drops `Irq` on the next edge.
- Auto-reload: write LOAD=2, then CTRL=0x3.
  - COUNT sequence is 2, 1, 0, 2, 1, 0, …
  - EXP sets 12 clocks after EN and stays set.
  - `Irq` stays 0 because IRQ_EN=0.
- Collisions:
  - A STATUS clear on the expiry edge leaves EXP=1.
  - A LOAD=7 write on a tick edge leaves COUNT=7.
- Protocol:
  - `Pselx` bit ≠ SEL_IDX with `Penable`=1 → no register change and `Prdata` stays 0.
  - A read followed immediately by a write with no idle cycle → `Prdata` correct in the access phase and 0 afterwards; the write commits.
